// File: rtl/pe_operand_feeder.sv
// Operand sequencer / result collector for a 4-lane dot-product PE over 4x4 A and B matrices.
// Optional result RAM with registered read port: `define PE_FEEDER_RESULT_RAM_EN.
module pe_operand_feeder #(
   parameter int HOLD = 8
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        wr_en,
   input  logic        wr_sel,
   input  logic [3:0]  wr_addr,
   input  logic [20:0] wr_data,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pe_en,
   output logic [83:0] pe_A,
   output logic [83:0] pe_B,
   input  logic [20:0] pe_c,
   output logic        res_valid,
   output logic [3:0]  res_addr,
   output logic [20:0] res_data
`ifdef PE_FEEDER_RESULT_RAM_EN
   ,
   input  logic [3:0]  rd_addr,
   output logic [20:0] rd_data
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

   state_t      state_q;
   logic [3:0]  idx_q;
   logic [3:0]  cnt_q;
   logic        busy_q;
   logic        done_q;
   logic        pe_en_q;
   logic        res_valid_q;
   logic [3:0]  res_addr_q;
   logic [20:0] res_data_q;

   logic [20:0] a_mem_q [16];
   logic [20:0] b_mem_q [16];
   logic        wr_commit_d;

   // Storage only changes while idle; a write alongside start still lands before the first RUN cycle.
   assign wr_commit_d = wr_en && (state_q == S_IDLE);

   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int k = 0; k < 16; k++) begin
            a_mem_q[k] <= '0;
            b_mem_q[k] <= '0;
         end
      end else if (wr_commit_d) begin
         if (wr_sel) begin
            b_mem_q[wr_addr] <= wr_data;
         end else begin
            a_mem_q[wr_addr] <= wr_data;
         end
      end
   end

   // Lane 0 occupies the top slice; A walks row idx[3:2], B walks column idx[1:0].
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         assign pe_A[83-21*gi -: 21] = a_mem_q[{idx_q[3:2], LANE}];
         assign pe_B[83-21*gi -: 21] = b_mem_q[{LANE, idx_q[1:0]}];
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pe_en_q     <= 1'b0;
         res_valid_q <= 1'b0;
         res_addr_q  <= '0;
         res_data_q  <= '0;
      end else begin
         res_valid_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_RUN;
                  idx_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  pe_en_q <= 1'b1;
               end
            end
            S_RUN: begin
               if (cnt_q == HOLD_LAST) begin
                  res_data_q  <= pe_c;
                  res_addr_q  <= idx_q;
                  res_valid_q <= 1'b1;
                  pe_en_q     <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= S_GAP;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            S_GAP: begin
               cnt_q <= '0;
               if (idx_q == 4'd15) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  idx_q   <= idx_q + 4'd1;
                  pe_en_q <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pe_en     = pe_en_q;
   assign res_valid = res_valid_q;
   assign res_addr  = res_addr_q;
   assign res_data  = res_data_q;

`ifdef PE_FEEDER_RESULT_RAM_EN
   logic [20:0] c_mem_q [16];
   logic [20:0] rd_data_q;

   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int k = 0; k < 16; k++) begin
            c_mem_q[k] <= '0;
         end
         rd_data_q <= '0;
      end else begin
         if (res_valid_q) begin
            c_mem_q[res_addr_q] <= res_data_q;
         end
         rd_data_q <= c_mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed bench for pe_operand_feeder with a behavioural 2-stage PE and a result scoreboard queue.
module tb_pe_operand_feeder;

   logic        CLK = 1'b0;
   logic        reset;
   logic        wr_en;
   logic        wr_sel;
   logic [3:0]  wr_addr;
   logic [20:0] wr_data;
   logic        start;
   logic        busy;
   logic        done;
   logic        pe_en;
   logic [83:0] pe_A;
   logic [83:0] pe_B;
   logic [20:0] pe_c;
   logic        res_valid;
   logic [3:0]  res_addr;
   logic [20:0] res_data;
`ifdef PE_FEEDER_RESULT_RAM_EN
   logic [3:0]  rd_addr;
   logic [20:0] rd_data;
`endif

   pe_operand_feeder #(.HOLD(8)) dut (
      .CLK       (CLK),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .pe_en     (pe_en),
      .pe_A      (pe_A),
      .pe_B      (pe_B),
      .pe_c      (pe_c),
      .res_valid (res_valid),
      .res_addr  (res_addr),
      .res_data  (res_data)
`ifdef PE_FEEDER_RESULT_RAM_EN
      ,
      .rd_addr   (rd_addr),
      .rd_data   (rd_data)
`endif
   );

   always #5 CLK = ~CLK;

   // Behavioural PE: dot product registered twice, product stage flushed while pe_en is low.
   logic [20:0] pe_p_q;
   logic [20:0] pe_c_q;

   function automatic logic [20:0] pe_dot(input logic [83:0] a, input logic [83:0] b);
      logic signed [47:0] s;
      logic signed [20:0] x;
      logic signed [20:0] y;
      s = '0;
      for (int l = 0; l < 4; l++) begin
         x = a[83-21*l -: 21];
         y = b[83-21*l -: 21];
         s = s + x * y;
      end
      return s[20:0];
   endfunction

   always @(posedge CLK) begin
      if (reset) begin
         pe_p_q <= '0;
         pe_c_q <= '0;
      end else begin
         pe_p_q <= pe_en ? pe_dot(pe_A, pe_B) : '0;
         pe_c_q <= pe_p_q;
      end
   end
   assign pe_c = pe_c_q;

   int passed = 0;
   int total  = 0;
   int sa [16];
   int sb [16];
   logic [24:0] exp_q [$];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wr(input bit sel, input int addr, input int data);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = 4'(addr);
      wr_data = 21'(data);
      if (sel) sb[addr] = data;
      else     sa[addr] = data;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic load_all(input int a_val, input int b_val);
      for (int k = 0; k < 16; k++) begin
         wr(1'b0, k, a_val);
         wr(1'b1, k, b_val);
      end
   endtask

   // Full run: expected results queued at start, popped on each res_valid.
   task automatic run_chk(input bit ws, input bit ws_sel, input int ws_addr, input int ws_data,
                          input int inj_cycle, input bit probe);
      int  nres;
      bit  got_done;
      int  s;
      logic [31:0] s_bits;
      logic [24:0] e;
      if (ws) begin
         wr_en   = 1'b1;
         wr_sel  = ws_sel;
         wr_addr = 4'(ws_addr);
         wr_data = 21'(ws_data);
         if (ws_sel) sb[ws_addr] = ws_data;
         else        sa[ws_addr] = ws_data;
      end
      exp_q.delete();
      for (int k = 0; k < 16; k++) begin
         s = 0;
         for (int t = 0; t < 4; t++) s += sa[(k/4)*4+t] * sb[t*4+(k%4)];
         s_bits = s;
         exp_q.push_back({4'(k), s_bits[20:0]});
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      check("busy_after_start", busy, 1);
      check("pe_en_after_start", pe_en, 1);
      nres = 0;
      got_done = 1'b0;
      for (int c = 1; c <= 200 && !got_done; c++) begin
         if (c == inj_cycle) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 21'h0ABCD; start = 1'b1;
         end else if (c == inj_cycle + 1) begin
            wr_en = 1'b0; start = 1'b0;
         end
         if (probe && c == 85) begin
            check("pack_pe_A_lane0", pe_A[83:63], 1);
            check("pack_pe_B_lane3", pe_B[20:0], 40);
         end
         if (res_valid) begin
            nres++;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               $display("result addr=%0d data=%0h", res_addr, res_data);
               check("res_addr", res_addr, e[24:21]);
               check("res_data", res_data, e[20:0]);
            end
         end
         if (done) begin
            got_done = 1'b1;
            check("done_cycle", c, 145);
         end else begin
            tick();
         end
      end
      check("run_completed", got_done, 1);
      check("result_count", nres, 16);
      tick();
      check("busy_after_done", busy, 0);
   endtask

   initial begin
      int nv;
      reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
`ifdef PE_FEEDER_RESULT_RAM_EN
      rd_addr = '0;
`endif
      for (int k = 0; k < 16; k++) begin sa[k] = 0; sb[k] = 0; end
      tick(); tick(); tick();
      reset = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pe_en", pe_en, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_addr", res_addr, 0);
      check("rst_res_data", res_data, 0);
      check("rst_pe_A_zero", (pe_A == '0), 1);
      check("rst_pe_B_zero", (pe_B == '0), 1);

      // Write visible through operand bus one cycle later (idx is 0 after reset).
      wr(1'b0, 0, 5);
      check("wr_visible_A0", pe_A[83:63], 5);
      wr(1'b1, 12, 9);
      check("wr_visible_B12", pe_B[20:0], 9);

      // Identity multiply; last B element written in the start cycle.
      for (int k = 0; k < 16; k++) wr(1'b0, k, (k / 4 == k % 4) ? 1 : 0);
      for (int k = 0; k < 15; k++) wr(1'b1, k, k + 1);
      run_chk(1'b1, 1'b1, 15, 16, 1000, 1'b0);
`ifdef PE_FEEDER_RESULT_RAM_EN
      rd_addr = 4'd7;
      tick();
      check("ram_rd_7", rd_data, 8);
      rd_addr = 4'd15;
      tick();
      check("ram_rd_15", rd_data, 16);
`endif
      // idx holds 15 in IDLE, so A[15] shows on lane 3.
      wr(1'b0, 15, 77);
      check("idle_wr_visible_A15", pe_A[20:0], 77);

      // Signed operands, then a second start on unchanged data.
      load_all(-1, 2);
      run_chk(1'b0, 1'b0, 0, 0, 1000, 1'b0);
      run_chk(1'b0, 1'b0, 0, 0, 1000, 1'b0);

      // Operand packing.
      load_all(0, 0);
      for (int t = 0; t < 4; t++) begin
         wr(1'b0, 8 + t, t + 1);
         wr(1'b1, t * 4 + 1, (t + 1) * 10);
      end
      run_chk(1'b0, 1'b0, 0, 0, 1000, 1'b1);

      // Write and start while busy must be ignored.
      run_chk(1'b0, 1'b0, 0, 0, 20, 1'b0);

      // Reset in the RUN window of position 5.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 48; c++) tick();
      check("pre_reset_pe_en", pe_en, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 16; k++) begin sa[k] = 0; sb[k] = 0; end
      check("midrst_busy", busy, 0);
      check("midrst_pe_en", pe_en, 0);
      check("midrst_res_valid", res_valid, 0);
      nv = 0;
      for (int c = 0; c < 30; c++) begin
         if (res_valid) nv++;
         tick();
      end
      check("midrst_no_results", nv, 0);
      check("midrst_storage_cleared", (pe_A == '0 && pe_B == '0), 1);
      run_chk(1'b0, 1'b0, 0, 0, 1000, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pe_operand_feeder.md
# pe_operand_feeder

Operand sequencer and result collector for one 4-element dot-product PE (four 21-bit signed multiply lanes, 3-stage adder tree, 21-bit result). It stores a 4x4 A matrix and a 4x4 B matrix loaded element-by-element. On `start`, it walks all 16 output positions in row-major order. For each position it drives row i of A and column j of B onto the PE's 84-bit operand buses, holds `pe_en` for a fixed window, then samples the PE result and emits it with its address.

## Interface

Parameters:
- `HOLD`, default 8: number of cycles `pe_en` is held per output position. It must be at least the PE latency from `en` rising to a stable `c`. Legal range is 2..15.

Ports (reset reset, synchronous, active-high; clock CLK):
- `CLK`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `wr_en`  in  1  matrix write strobe.
- `wr_sel`  in  1  write target: 0 = A, 1 = B.
- `wr_addr`  in  4  element index, row*4+col.
- `wr_data`  in  21  signed element value.
- `start`  in  1  single-cycle pulse that begins a 16-position run.
- `busy`  out  1  high from the cycle after an accepted `start` through the DONE state.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pe_en`  out  1  PE enable.
- `pe_A`  out  84  {A[i][0],A[i][1],A[i][2],A[i][3]}, with element 0 in [83:63].
- `pe_B`  out  84  {B[0][j],B[1][j],B[2][j],B[3][j]}, with element 0 in [83:63].
- `pe_c`  in  21  PE result.
- `res_valid`  out  1  one-cycle result strobe.
- `res_addr`  out  4  result index, i*4+j.
- `res_data`  out  21  sampled `pe_c`.

## Operation

State machine with four states.
- IDLE:
  - Writes are accepted here.
  - `start` moves the machine to RUN with idx=0, cnt=0.
- RUN:
  - `pe_en`=1.
  - Operands are selected combinationally from storage by idx (i=idx[3:2], j=idx[1:0]).
  - cnt increments each cycle.
  - When cnt==HOLD-1, `pe_c` is registered into `res_data`, idx into `res_addr`, and `res_valid` is set for the next cycle. The machine then moves to GAP.
- GAP:
  - `pe_en`=0 for exactly one cycle. This clears the PE control pipeline.
  - cnt returns to 0.
  - If idx==15 the machine goes to DONE. Otherwise idx increments and the machine returns to RUN.
- DONE:
  - `done`=1 for one cycle, then IDLE.

Arithmetic and storage:
- No arithmetic is done in this block.
- Values are stored and forwarded bit-exact as 21-bit two's complement.

Boundary conditions:
- `wr_en` while busy is ignored; storage is unchanged.
- `start` while busy is ignored.
- `start` and `wr_en` in the same IDLE cycle: the write commits, and the run uses the newly written value.
- Both matrices persist across runs. A second `start` recomputes using the same data unless it has been rewritten.
- `pe_A`/`pe_B` in IDLE/DONE: hold the operands for idx (last value). They are don't-care while `pe_en`=0.
- `reset` at any cycle, including mid-RUN:
  - Next state is IDLE.
  - idx and cnt return to 0.
  - A and B storage is cleared to 0.
  - Any pending `res_valid` is cancelled.

## Timing

Reset values of all outputs: `busy`=0, `done`=0, `pe_en`=0, `res_valid`=0, `res_addr`=0, `res_data`=0, `pe_A`=0, `pe_B`=0.

Per-cycle behaviour:
- `start` sampled in cycle T: first RUN cycle is T+1, and `pe_en` is high from T+1.
- Each position takes HOLD RUN cycles plus 1 GAP cycle.
- The `res_valid` for position k appears in the first cycle of GAP k.
- `done` is asserted in cycle T+1+16*(HOLD+1), which is T+145 for HOLD=8.
- `busy` falls the cycle after `done`.
- A write in cycle T is readable through `pe_A`/`pe_B` in cycle T+1.

## Configuration

`PE_FEEDER_RESULT_RAM_EN`:
- Defined:
  - Adds a 16x21 C storage written on every `res_valid`.
  - Adds ports `rd_addr` in 4 and `rd_data` out 21.
  - Read is registered: data appears the cycle after the address is presented.
  - C storage is cleared on reset and is readable in any state.
- Undefined:
  - The C storage and its ports are absent.
  - Results are available only via the `res_*` stream.

## Test plan

- **Identity multiply.** A=identity, B[r][c]=r*4+c+1, start → 16 `res_valid` pulses, addr 0..15 in order, with `res_data`=addr+1; `done` at start+145.
- **Signed operands.** All A=-1 (21'h1FFFFF), all B=2 → every `res_data`=-8 (21'h1FFFF8).
- **Operand packing.** A row 2 = {1,2,3,4}, B column 1 = {10,20,30,40}, all else 0 → addr 9 gives 300; every other result is 0. During position 9, `pe_A`[83:63]=1 and `pe_B`[20:0]=40.
- **Ignored inputs while busy.** `wr_en` to A[0] and a second `start` during busy → results are unchanged versus a golden run, and exactly 16 results are produced.
- **Reset mid-run.** Assert `reset` in the RUN cycle of idx=5 → the next cycle has `busy`=0, `pe_en`=0, and no further `res_valid`; a following run gives all 0 results.
- **Result RAM.** With `PE_FEEDER_RESULT_RAM_EN`, after the identity run, `rd_addr`=7 → `rd_data`=8 one cycle later.
